// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for a VGA-style display.
//
// Walks a pixel position (hpos, vpos) across an H_TOTAL x V_TOTAL raster, one
// step per clk edge with ce=1, and derives sync/blanking/marker strobes from it.
// Every output is a flop loaded from the *next* position, so all strobes line
// up with the hpos/vpos value presented in the same cycle.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   ce           pixel clock enable; all outputs hold while low
//   hsync        horizontal sync (asserted level set by SYNC_ACTIVE_LOW)
//   vsync        vertical sync   (asserted level set by SYNC_ACTIVE_LOW)
//   display_on   current position lies in the visible area
//   hpos, vpos   current pixel column / line (10 bits each)
//   line_start   hpos == 0
//   frame_start  hpos == 0 and vpos == 0
//   frame_count  frame index, 8 bits, wraps
//
// Build option:
//   VGA_TIMING_FRAME_COUNT_EN  when defined, frame_count counts frames;
//                              when undefined, frame_count is tied to 0 and
//                              no frame counter flops exist.
//
// Geometry limit: H_TOTAL and V_TOTAL must each be at most 1024.

module vga_timing_gen #(
  parameter int unsigned H_DISPLAY       = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_DISPLAY       = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned CMP_W   = POS_W + 1;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);

  // Region bounds kept one bit wider so an end bound of 1024 still compares correctly.
  localparam logic [CMP_W-1:0] H_DISP_END   = CMP_W'(H_DISPLAY);
  localparam logic [CMP_W-1:0] H_SYNC_BEGIN = CMP_W'(H_DISPLAY + H_FRONT);
  localparam logic [CMP_W-1:0] H_SYNC_END   = CMP_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CMP_W-1:0] V_DISP_END   = CMP_W'(V_DISPLAY);
  localparam logic [CMP_W-1:0] V_SYNC_BEGIN = CMP_W'(V_DISPLAY + V_FRONT);
  localparam logic [CMP_W-1:0] V_SYNC_END   = CMP_W'(V_DISPLAY + V_FRONT + V_SYNC);

  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [POS_W-1:0] h_next;
  logic [POS_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_wrap;
  logic             h_sync_act;
  logic             v_sync_act;
  logic             h_visible;
  logic             v_visible;

  // Next raster position and the decoded attributes of that position.
  always_comb begin
    h_wrap     = 1'b0;
    v_wrap     = 1'b0;
    frame_wrap = 1'b0;
    h_next     = hpos;
    v_next     = vpos;
    h_sync_act = 1'b0;
    v_sync_act = 1'b0;
    h_visible  = 1'b0;
    v_visible  = 1'b0;

    h_wrap     = (hpos == H_LAST);
    v_wrap     = (vpos == V_LAST);
    frame_wrap = h_wrap && v_wrap;

    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : vpos + POS_W'(1);
    end else begin
      h_next = hpos + POS_W'(1);
    end

    h_sync_act = ({1'b0, h_next} >= H_SYNC_BEGIN) && ({1'b0, h_next} < H_SYNC_END);
    v_sync_act = ({1'b0, v_next} >= V_SYNC_BEGIN) && ({1'b0, v_next} < V_SYNC_END);
    h_visible  = ({1'b0, h_next} < H_DISP_END);
    v_visible  = ({1'b0, v_next} < V_DISP_END);
  end

  // Position and strobe registers; reset parks on the last pixel of a frame
  // so the first enabled edge lands exactly on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hpos        <= h_next;
      vpos        <= v_next;
      hsync       <= h_sync_act ? SYNC_ON : SYNC_OFF;
      vsync       <= v_sync_act ? SYNC_ON : SYNC_OFF;
      display_on  <= h_visible && v_visible;
      line_start  <= h_wrap;
      frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_q;

  // Frame index; resets to 8'hFF so the first frame after reset reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= 8'hFF;
    end else if (ce && frame_wrap) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign frame_count = frame_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule
